// File: rtl/alu_accum_ctrl.sv
// Accumulator controller that sequences an external 4-bit ALU: load or ALU-op requests, one-cycle issue, ack until req drops.
// Optional macro ALU_CTRL_CARRY_CHAIN_EN feeds the carry register back into alu_cin for multi-word adds.
module alu_accum_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       load,
  input  logic [3:0] op,
  input  logic [3:0] operand,
  output logic       ack,
  output logic       busy,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_cin,
  input  logic [3:0] alu_result,
  input  logic       alu_cout,
  output logic [3:0] acc,
  output logic       carry,
  output logic       zero,
  output logic [1:0] state_dbg
);

  // Handshake: req is a level held by the requester; a request is accepted on
  // the first rising edge in IDLE with req=1. ack stays high in DONE until req
  // is sampled low, so the requester must drop req for at least one edge
  // between ack and its next request.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= 4'h0;
      carry  <= 1'b0;
      alu_a  <= 4'h0;
      alu_b  <= 4'h0;
      alu_op <= 4'h0;
      ack    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            busy <= 1'b1;
            if (load) begin
              acc   <= operand;
              carry <= 1'b0;
              ack   <= 1'b1;
              state <= DONE;
            end else begin
              alu_a  <= acc;
              alu_b  <= operand;
              alu_op <= op;
              ack    <= 1'b0;
              state  <= ISSUE;
            end
          end
        end
        // The ALU is combinational on the registered alu_* drive, so its
        // response is settled by the closing edge of this single cycle.
        ISSUE: begin
          acc   <= alu_result;
          carry <= alu_cout;
          ack   <= 1'b1;
          busy  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (!req) begin
            ack   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ack   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign zero      = (acc == 4'h0);
  assign state_dbg = state;

`ifdef ALU_CTRL_CARRY_CHAIN_EN
  assign alu_cin = carry;
`else
  assign alu_cin = 1'b0;
`endif

endmodule

// File: doc/alu_accum_ctrl.md
ALU_ACCUM_CTRL -- requirements
Module: alu_accum_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port req  input  1  operation request; level, held high by requester until ack seen.
REQ-004 SHALL have port load  input  1  sampled with req; 1 = load operand into accumulator, bypassing ALU.
REQ-005 SHALL have port op  input  4  ALU opcode (0000..1111, same encoding as the team ALU).
REQ-006 SHALL have port operand  input  4  second operand (ALU b) or load value.
REQ-007 SHALL have port ack  output  1  high while in DONE; request completed.
REQ-008 SHALL have port busy  output  1  high in ISSUE and DONE.
REQ-009 SHALL have ports alu_a, alu_b, alu_op  output  4 each  registered drive to ALU a, b, operation.
REQ-010 SHALL have port alu_cin  output  1  drive to ALU c_in.
REQ-011 SHALL have ports alu_result  input  4, alu_cout  input  1  combinational ALU response.
REQ-012 SHALL have port acc  output  4  accumulator register.
REQ-013 SHALL have port carry  output  1  carry flag register.
REQ-014 SHALL have port zero  output  1  combinational, high when acc == 0.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, DONE; encoding free, unreachable encodings return to IDLE.
REQ-016 IDLE, req=1, load=0: SHALL register alu_a<=acc, alu_b<=operand, alu_op<=op; next ISSUE.
REQ-017 IDLE, req=1, load=1: SHALL set acc<=operand, carry<=0; alu_* unchanged; next DONE.
REQ-018 ISSUE: SHALL, at the closing edge, capture acc<=alu_result, carry<=alu_cout; next DONE (ISSUE lasts exactly one cycle).
REQ-019 DONE: ack=1; SHALL stay in DONE while req=1 and move to IDLE on the first edge req=0 is sampled.
REQ-020 Latency: ack SHALL rise 2 edges after req is accepted (ALU op), 1 edge after acceptance (load).
REQ-021 op, operand and load SHALL be ignored outside IDLE; changes after acceptance SHALL not affect the operation.
REQ-022 req dropped during ISSUE SHALL not abort; DONE SHALL show ack for exactly one cycle, then IDLE.
REQ-023 acc and carry SHALL change only per REQ-017/REQ-018; carry taken from alu_cout for every opcode, no width extension.
REQ-024 Back-to-back requests SHALL need req low for at least one sampled edge between ack and next acceptance.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, acc=0, carry=0, alu_a=alu_b=alu_op=0, ack=0, busy=0, alu_cin=0 (zero=1).
REQ-026 Reset asserted mid-ISSUE or mid-DONE SHALL discard the operation; no capture after release.
REQ-027 After rst_n release, first acceptance SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-028 Macro ALU_CTRL_CARRY_CHAIN_EN defined: alu_cin SHALL equal the carry register (multi-word add chaining on op 1010).
REQ-029 Macro ALU_CTRL_CARRY_CHAIN_EN undefined: alu_cin SHALL be constant 0; carry register still updated and output.

Verification
REQ-030 Reset: rst_n=0 mid-run -> acc=0, carry=0, ack=0, busy=0, zero=1 without a clock edge.
REQ-031 Load: req=1, load=1, operand=4'h5 -> ack 1 edge later, acc=4'h5, carry=0, alu_* unchanged.
REQ-032 Add: acc=5, carry=0, op=1010, operand=4'hC, ALU attached -> ack 2 edges later, acc=4'h1, carry=1.
REQ-033 Chain: after REQ-032, op=1010, operand=0 -> acc=4'h2, carry=0 with CARRY_CHAIN_EN; acc=4'h1, carry=0 without.
REQ-034 Subtract: acc=3, op=1011, operand=5 -> acc=4'hE, carry=1; req held high 4 extra cycles -> ack stays high, then IDLE one edge after req=0.
REQ-035 Abort: req=1 accepted, rst_n pulsed low during ISSUE -> acc=0, no ack, state IDLE after release.
